// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction fetch sequencer: req/ack fetch toward imem, valid/ready toward decode.
// Optional misaligned-redirect trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef PC_MISALIGN_TRAP_EN
   ,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        misalign
);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      VALID,
      DRAIN
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc_q;
   logic [31:0] pc_nxt;
   logic [31:0] target;
   logic        imem_req_nxt;
   logic [31:0] imem_addr_nxt;
   logic        instr_valid_nxt;
   logic [31:0] instr_out_nxt;
   logic [31:0] instr_pc_nxt;

`ifdef PC_MISALIGN_TRAP_EN
   logic misalign_nxt;

   assign target       = (redirect_pc[1:0] != 2'b00) ? TRAP_VEC : redirect_pc;
   assign misalign_nxt = redirect_en && (redirect_pc[1:0] != 2'b00);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         misalign <= 1'b0;
      end else begin
         misalign <= misalign_nxt;
      end
   end
`else
   assign target   = redirect_pc;
   assign misalign = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         pc_q        <= RESET_PC;
         imem_req    <= 1'b0;
         imem_addr   <= RESET_PC;
         instr_valid <= 1'b0;
         instr_out   <= 32'h0000_0000;
         instr_pc    <= RESET_PC;
      end else begin
         state       <= state_nxt;
         pc_q        <= pc_nxt;
         imem_req    <= imem_req_nxt;
         imem_addr   <= imem_addr_nxt;
         instr_valid <= instr_valid_nxt;
         instr_out   <= instr_out_nxt;
         instr_pc    <= instr_pc_nxt;
      end
   end

   // Redirect outranks everything; an unacked fetch must finish in DRAIN before the new PC is used.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_q;
      case (state)
         IDLE: begin
            state_nxt = FETCH;
            if (redirect_en) pc_nxt = target;
         end
         FETCH: begin
            if (redirect_en) begin
               pc_nxt    = target;
               state_nxt = imem_ack ? FETCH : DRAIN;
            end else if (imem_ack) begin
               state_nxt = VALID;
            end
         end
         VALID: begin
            if (redirect_en) begin
               pc_nxt    = target;
               state_nxt = FETCH;
            end else if (instr_ready && !stall) begin
               pc_nxt    = pc_q + 32'd4;
               state_nxt = FETCH;
            end
         end
         DRAIN: begin
            if (redirect_en) pc_nxt = target;
            if (imem_ack) state_nxt = FETCH;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are computed from the next state so that every port comes straight from a flop.
   always_comb begin
      imem_req_nxt    = (state_nxt == FETCH) || (state_nxt == DRAIN);
      imem_addr_nxt   = imem_addr;
      instr_valid_nxt = (state_nxt == VALID);
      instr_out_nxt   = instr_out;
      instr_pc_nxt    = instr_pc;
      if (state_nxt == FETCH) imem_addr_nxt = pc_nxt;
      if ((state == FETCH) && imem_ack && !redirect_en) begin
         instr_out_nxt = imem_rdata;
         instr_pc_nxt  = pc_q;
      end
   end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: directed stimulus queues expected fetches/instructions, a monitor checks them.
// Memory model returns imem_addr + 0x13 after a programmable number of wait cycles.
module tb_pc_fetch_sequencer;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        misalign;

   int vectors;
   int miscompares;
   int mem_delay;
   int wait_cnt;

   logic [31:0] exp_fetch[$];
   logic [63:0] exp_instr[$];
   logic [31:0] exp_a;
   logic [63:0] exp_i;

`ifdef PC_MISALIGN_TRAP_EN
   localparam logic [31:0] MIS_PC   = 32'h0000_0100;
   localparam logic [31:0] MIS_DATA = 32'h0000_0113;
   localparam logic [31:0] MIS_FLAG = 32'h1;
`else
   localparam logic [31:0] MIS_PC   = 32'h0000_0102;
   localparam logic [31:0] MIS_DATA = 32'h0000_0115;
   localparam logic [31:0] MIS_FLAG = 32'h0;
`endif

   pc_fetch_sequencer dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .redirect_en(redirect_en),
      .redirect_pc(redirect_pc),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_rdata(imem_rdata),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr_out(instr_out),
      .instr_pc(instr_pc),
      .misalign(misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!instr_valid && n < 60) begin
         tick();
         n++;
      end
      if (!instr_valid) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL valid_timeout: instr_valid=%0b after %0d cycles, expected 1", instr_valid, n);
      end
   endtask

   task automatic apply_stimulus(input logic s, input logic rdy, input logic ren, input logic [31:0] rpc);
      stall       = s;
      instr_ready = rdy;
      redirect_en = ren;
      redirect_pc = rpc;
      tick();
      instr_ready = 1'b0;
      redirect_en = 1'b0;
   endtask

   // Memory: a new request starts counting after each ack; ack arrives once mem_delay wait cycles elapsed.
   always @(posedge clk) begin
      #1;
      if (imem_ack || !imem_req) wait_cnt = 0;
      if (imem_req && wait_cnt >= mem_delay) begin
         imem_ack   = 1'b1;
         imem_rdata = imem_addr + 32'h13;
      end else begin
         imem_ack = 1'b0;
         if (imem_req) wait_cnt++;
      end
   end

   // Monitor: every completed memory handshake and every decode transfer must match the next queued expectation.
   always @(negedge clk) begin
      if (imem_req && imem_ack) begin
         if (exp_fetch.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL fetch_unexpected: got addr 0x%08h, expected no fetch", imem_addr);
         end else begin
            exp_a = exp_fetch.pop_front();
            check_output("fetch_addr", imem_addr, exp_a);
         end
      end
      if (instr_valid && instr_ready && !stall && !redirect_en) begin
         if (exp_instr.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL instr_unexpected: got pc 0x%08h, expected no transfer", instr_pc);
         end else begin
            exp_i = exp_instr.pop_front();
            check_output("instr_pc", instr_pc, exp_i[63:32]);
            check_output("instr_out", instr_out, exp_i[31:0]);
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      mem_delay   = 0;
      wait_cnt    = 0;
      imem_ack    = 1'b0;
      imem_rdata  = 32'h0;
      rst         = 1'b0;
      stall       = 1'b0;
      instr_ready = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      check_output("reset_req", {31'h0, imem_req}, 32'h0);
      check_output("reset_addr", imem_addr, 32'h0);
      check_output("reset_valid", {31'h0, instr_valid}, 32'h0);
      check_output("reset_out", instr_out, 32'h0);
      check_output("reset_pc", instr_pc, 32'h0);
      check_output("reset_misalign", {31'h0, misalign}, 32'h0);

      // Reset then sequential fetch of 0x0, 0x4, 0x8.
      exp_fetch.push_back(32'h0);
      exp_fetch.push_back(32'h4);
      exp_fetch.push_back(32'h8);
      exp_instr.push_back({32'h0, 32'h13});
      exp_instr.push_back({32'h4, 32'h17});
      rst = 1'b1;
      wait_valid();
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      wait_valid();
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      wait_valid();

      // Stall holds the VALID word at 0x8 with no new request.
      stall       = 1'b1;
      instr_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_output("stall_valid", {31'h0, instr_valid}, 32'h1);
         check_output("stall_pc", instr_pc, 32'h8);
         check_output("stall_out", instr_out, 32'h1B);
         check_output("stall_req", {31'h0, imem_req}, 32'h0);
      end
      exp_instr.push_back({32'h8, 32'h1B});
      exp_fetch.push_back(32'hC);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("release_addr", imem_addr, 32'hC);
      check_output("release_req", {31'h0, imem_req}, 32'h1);
      wait_valid();

      // Slow memory: redirect on the first wait cycle sends the sequencer through DRAIN.
      mem_delay = 3;
      exp_instr.push_back({32'hC, 32'h1F});
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      exp_fetch.push_back(32'h10);
      exp_fetch.push_back(32'h200);
      apply_stimulus(1'b0, 1'b0, 1'b1, 32'h200);
      check_output("drain_addr_hold", imem_addr, 32'h10);
      check_output("drain_req_hold", {31'h0, imem_req}, 32'h1);
      check_output("aligned_misalign", {31'h0, misalign}, 32'h0);
      wait_valid();
      check_output("after_drain_pc", instr_pc, 32'h200);
      check_output("after_drain_out", instr_out, 32'h213);
      mem_delay = 0;

      // Redirect while VALID squashes the held word.
      exp_fetch.push_back(32'h10);
      apply_stimulus(1'b0, 1'b0, 1'b1, 32'h10);
      check_output("squash_valid", {31'h0, instr_valid}, 32'h0);
      wait_valid();

      // Accept and redirect together: redirect wins, no +4.
      exp_fetch.push_back(32'h80);
      apply_stimulus(1'b0, 1'b1, 1'b1, 32'h80);
      check_output("redir_vs_accept", imem_addr, 32'h80);
      wait_valid();

      // Wrap-around from 0xFFFFFFFC.
      exp_fetch.push_back(32'hFFFF_FFFC);
      apply_stimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      wait_valid();
      exp_instr.push_back({32'hFFFF_FFFC, 32'h0000_000F});
      exp_fetch.push_back(32'h0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      check_output("wrap_addr", imem_addr, 32'h0);
      wait_valid();

      // Misaligned redirect target.
      exp_fetch.push_back(MIS_PC);
      apply_stimulus(1'b0, 1'b0, 1'b1, 32'h102);
      check_output("misalign_pulse", {31'h0, misalign}, MIS_FLAG);
      check_output("misalign_addr", imem_addr, MIS_PC);
      tick();
      check_output("misalign_clear", {31'h0, misalign}, 32'h0);
      wait_valid();
      exp_instr.push_back({MIS_PC, MIS_DATA});
      exp_fetch.push_back(MIS_PC + 32'h4);
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      wait_valid();

      // Asynchronous reset mid-operation.
      rst = 1'b0;
      #1;
      check_output("midreset_valid", {31'h0, instr_valid}, 32'h0);
      check_output("midreset_pc", instr_pc, 32'h0);
      check_output("midreset_out", instr_out, 32'h0);
      check_output("midreset_addr", imem_addr, 32'h0);
      check_output("midreset_req", {31'h0, imem_req}, 32'h0);
      repeat (3) tick();

      check_output("fetch_queue_empty", exp_fetch.size(), 32'h0);
      check_output("instr_queue_empty", exp_instr.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
